hex_digit_counter: RTL

- Rate-divided 4-bit hex counter, stage directly upstream of the 7-segment hex decoder.
- Produces the nibble that the decoder turns into active-low segment drive (HEX0).
- The count steps once per divided period: up or down, with parallel load, enable and a selectable rate.
- Also emits a step tick and a wrap pulse, which a following digit can chain from.

---
 rtl/hex_digit_counter.sv | 81 ++++++++
 1 files changed

// File: rtl/hex_digit_counter.sv
// Rate-divided 4-bit hex digit counter feeding the 7-segment decoder; count/tick/wrap are registered.
// Steps once per divided period (no backpressure); priority: reset > load > speed change > enable/step.
module hex_digit_counter #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       tick,
    output logic       wrap
);
    localparam int DIV_W = $clog2(4 * CLK_FREQ);

    // Divider reload value: PERIOD(s) - 1, so a step lands on the PERIOD-th enabled edge.
    function automatic logic [DIV_W-1:0] period_m1(input logic [1:0] s);
        case (s)
            2'd0:    return '0;
            2'd1:    return DIV_W'(CLK_FREQ - 1);
            2'd2:    return DIV_W'(2 * CLK_FREQ - 1);
            default: return DIV_W'(4 * CLK_FREQ - 1);
        endcase
    endfunction

    logic [3:0]       count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       speed_q, speed_d;

    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        speed_d = speed_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (reset) begin
            count_d = 4'h0;
            speed_d = speed;
            div_d   = period_m1(speed);
        end else if (load) begin
            count_d = load_value;
            speed_d = speed;
            div_d   = period_m1(speed);
        end else if (speed != speed_q) begin
            // A rate change restarts the period rather than finishing the old one.
            speed_d = speed;
            div_d   = period_m1(speed);
        end else if (enable) begin
            if (div_q != '0) begin
                div_d = div_q - 1'b1;
            end else begin
                tick_d = 1'b1;
                div_d  = period_m1(speed_q);
                if (up_down) begin
                    count_d = count_q + 4'd1;
                    wrap_d  = (count_q == 4'hF);
                end else begin
                    count_d = count_q - 4'd1;
                    wrap_d  = (count_q == 4'h0);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
        tick_q  <= tick_d;
        wrap_q  <= wrap_d;
        div_q   <= div_d;
        speed_q <= speed_d;
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;
endmodule
